// File: rtl/c64_bus_pkg.sv
// Shared types and constants for the expansion-port DMA sequencer.
package c64_bus_pkg;

  // Sequencer phases across one PHI2 cycle
  typedef enum logic [3:0] {
    ST_RESET,
    ST_WAIT_LO,
    ST_LO_REL,
    ST_LO_ARB,
    ST_WAIT_HI,
    ST_ADDR,
    ST_LOAD,
    ST_DRIVE,
    ST_DATA,
    ST_OPEN,
    ST_CAPTURE
  } seq_state_e;

  localparam logic DIR_TO_BUS   = 1'b1;
  localparam logic DIR_FROM_BUS = 1'b0;

  localparam logic [15:0] FF00_ADDR = 16'hFF00;

  // Width of a channel index; at least one bit even for a single channel
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first pending channel at or after ptr, wrapping to 0.
module rr_arbiter
  import c64_bus_pkg::*;
#(
  parameter int unsigned NUM_CH = 2
) (
  input  logic [NUM_CH-1:0]         pending,
  input  logic [idx_w(NUM_CH)-1:0]  ptr,
  output logic [idx_w(NUM_CH)-1:0]  grant_idx,
  output logic                      any_pending
);

  localparam int unsigned GW = idx_w(NUM_CH);

  logic          hi_found;
  logic          lo_found;
  logic [GW-1:0] hi_idx;
  logic [GW-1:0] lo_idx;

  // Lowest pending index at/above ptr wins, else lowest pending overall
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (pending[i]) begin
        if (!hi_found && (GW'(i) >= ptr)) begin
          hi_found = 1'b1;
          hi_idx   = GW'(i);
        end
        if (!lo_found) begin
          lo_found = 1'b1;
          lo_idx   = GW'(i);
        end
      end
    end
    any_pending = lo_found;
    grant_idx   = hi_found ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/dma_bus_sequencer.sv
// Multi-channel expansion-port DMA master. Optional macro FF00_TRIGGER_EN
// builds the CPU-write-to-$FF00 strobe; otherwise ff00_w_strobe is tied low.
module dma_bus_sequencer
  import c64_bus_pkg::*;
#(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned AW       = 16,
  parameter int unsigned DW       = 8,
  parameter int unsigned BA_STALL = 3,
  parameter int unsigned REL_DLY  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 phi,
  input  logic                 ba,
  input  logic                 rw_in,
  input  logic [AW-1:0]        a_d,
  input  logic [DW-1:0]        d_d,
  output logic [AW-1:0]        a_q,
  output logic [DW-1:0]        d_q,
  output logic                 a_oe,
  output logic                 d_oe,
  output logic                 as_dir,
  output logic                 ds_dir,
  output logic                 as_en_n,
  output logic                 ds_en_n,
  output logic                 rw_out,
  output logic                 dma,
  input  logic [NUM_CH-1:0]    ch_req,
  output logic [NUM_CH-1:0]    ch_ack,
  input  logic [NUM_CH*AW-1:0] ch_a,
  input  logic [NUM_CH*DW-1:0] ch_d,
  input  logic [NUM_CH-1:0]    ch_rw,
  output logic [DW-1:0]        dma_q,
  output logic                 dma_q_valid,
  output logic [2:0]           dma_ch,
  output logic                 ff00_w_strobe
);

  localparam int unsigned GW  = idx_w(NUM_CH);
  localparam int unsigned CNW = 3;

  seq_state_e state, state_nxt;

  logic phi_s1, phi_s2, phi_d;
  logic phi_rise, phi_fall;

  logic [NUM_CH-1:0] pending;
  logic [GW-1:0]     grant, rr_ptr, arb_idx;
  logic              grant_valid, arb_any;
  logic              keep_grant, take_grant, can_dma;
  logic [CNW-1:0]    rel_cnt, ba_cnt;
  logic [1:0]        rw_log;

  logic [AW-1:0]     g_a;
  logic [DW-1:0]     g_d;
  logic              g_rw;

  logic [AW-1:0]     a_q_nxt;
  logic [DW-1:0]     d_q_nxt, dma_q_nxt;
  logic              a_oe_nxt, d_oe_nxt, as_dir_nxt, ds_dir_nxt;
  logic              as_en_n_nxt, ds_en_n_nxt, rw_out_nxt, dma_nxt, dma_q_valid_nxt;
  logic [NUM_CH-1:0] ch_ack_nxt;
  logic [2:0]        dma_ch_nxt;

  // Two-flop PHI synchroniser plus edge history (no reset: pure sampling)
  always_ff @(posedge clk) begin
    phi_s1 <= phi;
    phi_s2 <= phi_s1;
    phi_d  <= phi_s2;
  end

  assign phi_rise = phi_s2 & ~phi_d;
  assign phi_fall = ~phi_s2 & phi_d;

  assign pending = ch_req ^ ch_ack;
  assign g_a     = ch_a[grant*AW +: AW];
  assign g_d     = ch_d[grant*DW +: DW];
  assign g_rw    = ch_rw[grant];

  // CPU is known halted after BA_STALL low samples, or after a write followed by a read
  assign can_dma    = (ba_cnt == CNW'(BA_STALL)) | (rw_log == 2'b01);
  assign keep_grant = grant_valid & pending[grant];
  assign take_grant = ~keep_grant & arb_any & (can_dma | dma);

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .pending     (pending),
    .ptr         (rr_ptr),
    .grant_idx   (arb_idx),
    .any_pending (arb_any)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_RESET;
    else     state <= state_nxt;
  end

  // Next-state sequencing through one PHI2 cycle
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RESET:   state_nxt = ST_WAIT_LO;
      ST_WAIT_LO: if (phi_fall) state_nxt = ST_LO_REL;
      ST_LO_REL:  if (rel_cnt == CNW'(REL_DLY - 1)) state_nxt = ST_LO_ARB;
      ST_LO_ARB:  state_nxt = ST_WAIT_HI;
      ST_WAIT_HI: if (phi_rise) state_nxt = (dma & ba) ? ST_ADDR : ST_WAIT_LO;
      ST_ADDR:    state_nxt = ST_LOAD;
      ST_LOAD:    state_nxt = ST_DRIVE;
      ST_DRIVE:   state_nxt = ST_DATA;
      ST_DATA:    state_nxt = ST_OPEN;
      ST_OPEN:    state_nxt = ST_CAPTURE;
      ST_CAPTURE: if (phi_fall) state_nxt = ST_LO_REL;
      default:    state_nxt = ST_RESET;
    endcase
  end

  // Output next-values: hold by default, each phase updates its own pins
  always_comb begin
    a_q_nxt         = a_q;
    d_q_nxt         = d_q;
    a_oe_nxt        = a_oe;
    d_oe_nxt        = d_oe;
    as_dir_nxt      = as_dir;
    ds_dir_nxt      = ds_dir;
    as_en_n_nxt     = as_en_n;
    ds_en_n_nxt     = ds_en_n;
    rw_out_nxt      = rw_out;
    dma_nxt         = dma;
    ch_ack_nxt      = ch_ack;
    dma_q_nxt       = dma_q;
    dma_q_valid_nxt = 1'b0;
    dma_ch_nxt      = dma_ch;
    case (state)
      ST_RESET: begin
        a_oe_nxt    = 1'b0;
        d_oe_nxt    = 1'b0;
        rw_out_nxt  = 1'b0;
        dma_nxt     = 1'b0;
        as_en_n_nxt = 1'b0;
        ds_en_n_nxt = 1'b1;
      end
      ST_LO_REL: begin
        if (rel_cnt == CNW'(REL_DLY - 1)) begin
          as_en_n_nxt = 1'b1;
          ds_en_n_nxt = 1'b1;
          a_oe_nxt    = 1'b0;
          d_oe_nxt    = 1'b0;
        end
      end
      ST_LO_ARB: begin
        as_dir_nxt = DIR_FROM_BUS;
        ds_dir_nxt = DIR_FROM_BUS;
        rw_out_nxt = 1'b0;
        if (take_grant)                  dma_nxt = 1'b1;
        else if (!keep_grant && !arb_any) dma_nxt = 1'b0;
      end
      ST_WAIT_HI: as_en_n_nxt = 1'b0;
      ST_ADDR:    as_en_n_nxt = 1'b1;
      ST_LOAD: begin
        a_q_nxt    = g_a;
        d_q_nxt    = g_d;
        as_dir_nxt = DIR_TO_BUS;
        ds_dir_nxt = g_rw;
      end
      ST_DRIVE: begin
        as_en_n_nxt = 1'b0;
        a_oe_nxt    = 1'b1;
        rw_out_nxt  = g_rw;
      end
      ST_DATA: d_oe_nxt = g_rw;
      ST_OPEN: ds_en_n_nxt = 1'b0;
      ST_CAPTURE: begin
        if (phi_s2) dma_q_nxt = d_d;
        if (phi_fall) begin
          ch_ack_nxt[grant] = ~ch_ack[grant];
          dma_q_valid_nxt   = 1'b1;
          dma_ch_nxt        = 3'(grant);
        end
      end
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q         <= '0;
      d_q         <= '0;
      a_oe        <= 1'b0;
      d_oe        <= 1'b0;
      as_dir      <= 1'b0;
      ds_dir      <= 1'b0;
      as_en_n     <= 1'b0;
      ds_en_n     <= 1'b1;
      rw_out      <= 1'b0;
      dma         <= 1'b0;
      ch_ack      <= '0;
      dma_q       <= '0;
      dma_q_valid <= 1'b0;
      dma_ch      <= '0;
    end else begin
      a_q         <= a_q_nxt;
      d_q         <= d_q_nxt;
      a_oe        <= a_oe_nxt;
      d_oe        <= d_oe_nxt;
      as_dir      <= as_dir_nxt;
      ds_dir      <= ds_dir_nxt;
      as_en_n     <= as_en_n_nxt;
      ds_en_n     <= ds_en_n_nxt;
      rw_out      <= rw_out_nxt;
      dma         <= dma_nxt;
      ch_ack      <= ch_ack_nxt;
      dma_q       <= dma_q_nxt;
      dma_q_valid <= dma_q_valid_nxt;
      dma_ch      <= dma_ch_nxt;
    end
  end

  // Grant latch and round-robin pointer: held until completion or withdrawal
  always_ff @(posedge clk) begin
    if (rst) begin
      grant       <= '0;
      grant_valid <= 1'b0;
      rr_ptr      <= '0;
    end else if (state == ST_LO_ARB && !keep_grant) begin
      grant_valid <= take_grant;
      if (take_grant) grant <= arb_idx;
    end else if (state == ST_CAPTURE && phi_fall) begin
      grant_valid <= 1'b0;
      rr_ptr      <= (grant == GW'(NUM_CH - 1)) ? '0 : grant + 1'b1;
    end
  end

  // Release delay counter, restarts each time LO_REL is entered
  always_ff @(posedge clk) begin
    if (rst || state != ST_LO_REL) rel_cnt <= '0;
    else                           rel_cnt <= rel_cnt + 1'b1;
  end

  // CPU-halt tracking; R/W history starts as idle reads
  always_ff @(posedge clk) begin
    if (rst) begin
      ba_cnt <= '0;
      rw_log <= 2'b11;
    end else begin
      if (phi_rise) begin
        if (ba)                              ba_cnt <= '0;
        else if (ba_cnt != CNW'(BA_STALL))   ba_cnt <= ba_cnt + 1'b1;
      end
      if (phi_fall) rw_log <= {rw_log[0], rw_in | dma};
    end
  end

`ifdef FF00_TRIGGER_EN
  logic fall_d;

  // CPU write to $FF00 sampled one clk after PHI fall
  always_ff @(posedge clk) begin
    if (rst) begin
      fall_d        <= 1'b0;
      ff00_w_strobe <= 1'b0;
    end else begin
      fall_d        <= phi_fall;
      ff00_w_strobe <= fall_d & ~rw_in & (a_d == AW'(FF00_ADDR));
    end
  end
`else
  logic unused_a_d;

  assign ff00_w_strobe = 1'b0;
  assign unused_a_d    = ^a_d;
`endif

endmodule

// File: tb/tb_dma_bus_sequencer.sv
// Randomised bench for dma_bus_sequencer against a per-PHI-cycle transaction model.
module tb_dma_bus_sequencer;

  localparam int NCH      = 2;
  localparam int AW       = 16;
  localparam int DW       = 8;
  localparam int BA_STALL = 3;
  localparam int ITERS    = 140;

  logic              clk, rst, phi, ba, rw_in;
  logic [AW-1:0]     a_d, a_q;
  logic [DW-1:0]     d_d, d_q, dma_q;
  logic              a_oe, d_oe, as_dir, ds_dir, as_en_n, ds_en_n, rw_out, dma;
  logic [NCH-1:0]    ch_req, ch_ack, ch_rw;
  logic [NCH*AW-1:0] ch_a;
  logic [NCH*DW-1:0] ch_d;
  logic              dma_q_valid, ff00_w_strobe;
  logic [2:0]        dma_ch;

  dma_bus_sequencer dut (
    .clk(clk), .rst(rst), .phi(phi), .ba(ba), .rw_in(rw_in),
    .a_d(a_d), .d_d(d_d), .a_q(a_q), .d_q(d_q),
    .a_oe(a_oe), .d_oe(d_oe), .as_dir(as_dir), .ds_dir(ds_dir),
    .as_en_n(as_en_n), .ds_en_n(ds_en_n), .rw_out(rw_out), .dma(dma),
    .ch_req(ch_req), .ch_ack(ch_ack), .ch_a(ch_a), .ch_d(ch_d), .ch_rw(ch_rw),
    .dma_q(dma_q), .dma_q_valid(dma_q_valid), .dma_ch(dma_ch),
    .ff00_w_strobe(ff00_w_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Pulse observers
  int          v_cnt = 0, s_cnt = 0;
  logic [2:0]  v_ch;
  logic [7:0]  v_q;
  always @(posedge clk) begin
    if (dma_q_valid) begin
      v_cnt <= v_cnt + 1;
      v_ch  <= dma_ch;
      v_q   <= dma_q;
    end
    if (ff00_w_strobe) s_cnt <= s_cnt + 1;
  end

  // Transaction-level model state
  bit [NCH-1:0] m_req, m_ack;
  logic [15:0]  m_a [NCH];
  logic [7:0]   m_d [NCH];
  bit           m_rw [NCH];
  int           m_ptr, m_g, m_ba_cnt;
  bit           m_gv, m_dma, m_xfer;
  bit [1:0]     m_rwlog;
  logic [7:0]   m_dd;
  bit           exp_valid, exp_strobe;
  int           exp_ch;
  logic [7:0]   exp_q;

  task automatic model_reset();
    m_ack = '0; m_ptr = 0; m_g = 0; m_gv = 0; m_dma = 0;
    m_ba_cnt = 0; m_rwlog = 2'b11; m_xfer = 0;
  endtask

  task automatic drive_channels();
    for (int i = 0; i < NCH; i++) begin
      ch_a[i*AW +: AW] = m_a[i];
      ch_d[i*DW +: DW] = m_d[i];
      ch_rw[i]         = m_rw[i];
    end
    ch_req = m_req;
  endtask

  // End of a PHI cycle: completion, R/W history, then low-phase arbitration
  task automatic model_fall();
    bit [NCH-1:0] pend;
    bit can;
    exp_valid = m_xfer;
    if (m_xfer) begin
      m_ack[m_g] = ~m_ack[m_g];
      exp_ch     = m_g;
      exp_q      = m_dd;
      m_ptr      = (m_g + 1) % NCH;
      m_gv       = 0;
    end
`ifdef FF00_TRIGGER_EN
    exp_strobe = (rw_in == 1'b0) && (a_d == 16'hFF00);
`else
    exp_strobe = 0;
`endif
    m_rwlog = {m_rwlog[0], rw_in | m_dma};
    m_xfer  = 0;
    pend    = m_req ^ m_ack;
    can     = (m_ba_cnt == BA_STALL) || (m_rwlog == 2'b01);
    if (!(m_gv && pend[m_g])) begin
      m_gv = 0;
      if (pend == '0) m_dma = 0;
      else if (can || m_dma) begin
        for (int k = NCH - 1; k >= 0; k--)
          if (pend[(m_ptr + k) % NCH]) m_g = (m_ptr + k) % NCH;
        m_gv  = 1;
        m_dma = 1;
      end
    end
  endtask

  task automatic model_rise();
    if (ba) m_ba_cnt = 0;
    else if (m_ba_cnt < BA_STALL) m_ba_cnt++;
    m_xfer = m_dma && ba;
  endtask

  int  v_base, s_base;
  bit  rst_done;
  bit  do_rst;

  initial begin
    rst = 1'b1; phi = 1'b1; ba = 1'b1; rw_in = 1'b1;
    a_d = '0; d_d = '0; ch_req = '0; ch_a = '0; ch_d = '0; ch_rw = '0;
    m_req = '0; m_dd = '0; rst_done = 0;
    for (int i = 0; i < NCH; i++) begin m_a[i] = '0; m_d[i] = '0; m_rw[i] = 0; end
    model_reset();
    repeat (6) @(posedge clk);
    #1;
    check("rst_a_oe", a_oe, 0);
    check("rst_d_oe", d_oe, 0);
    check("rst_dma", dma, 0);
    check("rst_rw_out", rw_out, 0);
    check("rst_as_en_n", as_en_n, 0);
    check("rst_ds_en_n", ds_en_n, 1);
    check("rst_ch_ack", ch_ack, 0);
    check("rst_valid", dma_q_valid, 0);
    check("rst_strobe", ff00_w_strobe, 0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // ch0 write D020/05 and ch1 read 8000 both pending; CPU write before first fall
    m_a[0] = 16'hD020; m_d[0] = 8'h05; m_rw[0] = 1;
    m_a[1] = 16'h8000; m_d[1] = 8'h00; m_rw[1] = 0;
    m_req = 2'b11;
    drive_channels();
    rw_in = 1'b0;

    for (int it = 0; it < ITERS; it++) begin
      // PHI low half
      @(posedge clk); #1 phi = 1'b0;
      model_fall();
      v_base = v_cnt; s_base = s_cnt;
      repeat (10) @(posedge clk);
      #1;
      check("lo_ch_ack", ch_ack, m_ack);
      check("lo_dma", dma, m_dma);
      check("lo_valid_cnt", v_cnt - v_base, exp_valid ? 1 : 0);
      if (exp_valid) begin
        check("lo_dma_ch", v_ch, exp_ch);
        check("lo_dma_q", v_q, exp_q);
      end
      check("lo_strobe_cnt", s_cnt - s_base, exp_strobe ? 1 : 0);
      check("lo_a_oe", a_oe, 0);
      check("lo_d_oe", d_oe, 0);
      check("lo_rw_out", rw_out, 0);
      check("lo_as_en_n", as_en_n, 0);
      check("lo_ds_en_n", ds_en_n, 1);
      ba = (it < 2) ? 1'b1 : (($urandom % 4) != 0);
      repeat (6) @(posedge clk);
      #1 phi = 1'b1;
      model_rise();

      // PHI high half
      @(posedge clk); #1;
      d_d  = 8'($urandom);
      m_dd = d_d;
      do_rst = m_xfer && !rst_done;
      if (do_rst) begin
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_a_oe", a_oe, 0);
        check("rst_mid_d_oe", d_oe, 0);
        check("rst_mid_dma", dma, 0);
        check("rst_mid_rw_out", rw_out, 0);
        check("rst_mid_ch_ack", ch_ack, m_ack);
        model_reset();
        rst_done = 1;
        @(posedge clk); #1 rst = 1'b0;
        repeat (4) @(posedge clk);
      end else begin
        repeat (11) @(posedge clk);
      end
      #1;
      check("hi_dma", dma, m_dma);
      if (m_xfer) begin
        check("hi_a_oe", a_oe, 1);
        check("hi_a_q", a_q, m_a[m_g]);
        check("hi_d_q", d_q, m_d[m_g]);
        check("hi_rw_out", rw_out, m_rw[m_g]);
        check("hi_d_oe", d_oe, m_rw[m_g]);
        check("hi_ds_dir", ds_dir, m_rw[m_g]);
        check("hi_as_dir", as_dir, 1);
        check("hi_as_en_n", as_en_n, 0);
        check("hi_ds_en_n", ds_en_n, 0);
      end else begin
        check("hi_idle_a_oe", a_oe, 0);
        check("hi_idle_d_oe", d_oe, 0);
        check("hi_idle_rw_out", rw_out, 0);
      end

      // New CPU cycle and requester activity, sampled at the coming PHI fall
      if (it == 0) begin
        rw_in = 1'b1;
        a_d   = 16'h1234;
      end else if (it % 5 == 2) begin
        rw_in = 1'b0;
        a_d   = 16'hFF00;
      end else begin
        rw_in = (($urandom % 3) != 0);
        a_d   = 16'($urandom);
      end
      for (int i = 0; i < NCH; i++) begin
        bit pend;
        pend = m_req[i] ^ m_ack[i];
        if (!pend && ($urandom % 3) == 0) begin
          m_a[i]  = 16'($urandom);
          m_d[i]  = 8'($urandom);
          m_rw[i] = 1'($urandom);
          m_req[i] = ~m_req[i];
        end else if (pend && it >= 30 && !(m_xfer && m_g == i) && ($urandom % 8) == 0) begin
          m_req[i] = ~m_req[i];
        end
      end
      drive_channels();
      repeat (3) @(posedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
